// File: rtl/pixel_line_arbiter.sv
// Line-atomic round-robin arbiter: two pixel producers share one registered valid/ready output.
// Latency: request seen in IDLE -> grant next cycle -> beat accepted that cycle -> out_valid one cycle later.
// Backpressure: reqN_ready = grant && (!out_valid || out_ready); no skid buffer, output holds while stalled.
module pixel_line_arbiter #(
  parameter int PIX_W    = 24,
  parameter int MAX_LINE = 1024,
  parameter int CNT_W    = 11
) (
  input  logic             cp,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [PIX_W-1:0] req0_pixel,
  input  logic             req0_eol,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [PIX_W-1:0] req1_pixel,
  input  logic             req1_eol,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_eol,
  output logic             out_src,
  input  logic             out_ready,
  output logic             trunc_err,
  output logic [15:0]      lines_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]       state;
  logic             ptr;
  logic [CNT_W-1:0] cnt;

  logic             out_free;
  logic             acc0;
  logic             acc1;
  logic             acc;
  logic [PIX_W-1:0] sel_pixel;
  logic             sel_eol;
  logic             at_max;
  logic             beat_eol;

  assign out_free   = !out_valid || out_ready;
  assign req0_ready = (state == GNT0) && out_free;
  assign req1_ready = (state == GNT1) && out_free;

  assign acc0      = req0_valid && req0_ready;
  assign acc1      = req1_valid && req1_ready;
  assign acc       = acc0 || acc1;
  assign sel_pixel = acc1 ? req1_pixel : req0_pixel;
  assign sel_eol   = acc1 ? req1_eol : req0_eol;
  // A line that reaches MAX_LINE beats is closed here even without a real eol.
  assign at_max    = (cnt == CNT_W'(MAX_LINE - 1));
  assign beat_eol  = sel_eol || at_max;

  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_eol    <= 1'b0;
      out_src    <= 1'b0;
      trunc_err  <= 1'b0;
      lines_done <= 16'd0;
    end else begin
      trunc_err <= 1'b0;

      case (state)
        IDLE: begin
          if (req0_valid && (!req1_valid || !ptr)) state <= GNT0;
          else if (req1_valid)                     state <= GNT1;
        end
        GNT0, GNT1: ;
        default: state <= IDLE;
      endcase

      if (acc) begin
        out_valid <= 1'b1;
        out_pixel <= sel_pixel;
        out_eol   <= beat_eol;
        out_src   <= acc1;
        if (beat_eol) begin
          state      <= IDLE;
          cnt        <= '0;
          ptr        <= !acc1;
          lines_done <= lines_done + 16'd1;
          trunc_err  <= !sel_eol;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_line_arbiter.sv
// Scoreboard bench for pixel_line_arbiter: drivers push expected beats, a monitor pops on each handshake.
// Latency: checks grant-to-output timing and inter-line bubble from the observation log.
// Backpressure: exercises output stall, truncation at MAX_LINE and asynchronous reset mid-line.
module tb_pixel_line_arbiter;

  localparam int PW   = 24;
  localparam int MAXL = 8;
  localparam int CW   = 4;

  logic          cp = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid, req0_eol, req0_ready;
  logic [PW-1:0] req0_pixel;
  logic          req1_valid, req1_eol, req1_ready;
  logic [PW-1:0] req1_pixel;
  logic          out_valid, out_eol, out_src, out_ready;
  logic [PW-1:0] out_pixel;
  logic          trunc_err;
  logic [15:0]   lines_done;

  pixel_line_arbiter #(.PIX_W(PW), .MAX_LINE(MAXL), .CNT_W(CW)) dut (
    .cp(cp), .reset(reset),
    .req0_valid(req0_valid), .req0_pixel(req0_pixel), .req0_eol(req0_eol), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_pixel(req1_pixel), .req1_eol(req1_eol), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_eol(out_eol), .out_src(out_src),
    .out_ready(out_ready), .trunc_err(trunc_err), .lines_done(lines_done)
  );

  always #5 cp = ~cp;

  int cyc = 0;
  always @(posedge cp) cyc <= cyc + 1;

  typedef struct packed {
    logic [PW-1:0] pix;
    logic          eol;
    logic          src;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } obs_t;

  beat_t exp_q[$];
  obs_t  log_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    mcnt[2];
  int    m_lines = 0;
  int    n_trunc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Outputs are sampled mid low-phase, after all inputs have settled for the cycle.
  always @(negedge cp) begin
    beat_t got;
    beat_t e;
    #3;
    if (!reset && out_valid && out_ready) begin
      got = '{out_pixel, out_eol, out_src};
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {6'd0, got}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {6'd0, got}, {6'd0, e});
      end
      log_q.push_back('{got, cyc});
    end
    if (!reset && trunc_err) begin
      n_trunc++;
      chk("trunc_on_eol_beat", {30'd0, out_valid, out_eol}, 32'd3);
    end
  end

  task automatic set_req(input int n, input logic v, input logic [PW-1:0] p, input logic e);
    if (n == 0) begin
      req0_valid = v; req0_pixel = p; req0_eol = e;
    end else begin
      req1_valid = v; req1_pixel = p; req1_eol = e;
    end
  endtask

  function automatic logic rdy(input int n);
    return (n != 0) ? req1_ready : req0_ready;
  endfunction

  task automatic send(input int n, input logic [PW-1:0] px0, input int len,
                      input bit last_eol, input int stop_after, output int t0);
    logic e;
    logic ee;
    int   w;
    t0 = 0;
    for (int i = 0; i < len; i++) begin
      if (i == stop_after) return;
      @(negedge cp); #1;
      e = last_eol && (i == len - 1);
      set_req(n, 1'b1, px0 + PW'(i), e);
      if (i == 0) t0 = cyc;
      #1;
      w = 0;
      while (!rdy(n) && w < 300) begin
        @(negedge cp); #2;
        w++;
      end
      if (w >= 300) begin
        chk("ready_timeout", 32'd0, 32'd1);
        set_req(n, 1'b0, '0, 1'b0);
        return;
      end
      ee = e || (mcnt[n] == MAXL - 1);
      mcnt[n] = ee ? 0 : mcnt[n] + 1;
      if (ee) m_lines++;
      exp_q.push_back('{px0 + PW'(i), ee, n[0]});
      @(posedge cp); #1;
      set_req(n, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge cp); #4;
      w++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    @(negedge cp); #4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, base, w;
    logic [PW-1:0] hold_pix;
    req0_valid = 0; req0_pixel = '0; req0_eol = 0;
    req1_valid = 0; req1_pixel = '0; req1_eol = 0;
    out_ready  = 1;
    mcnt[0] = 0; mcnt[1] = 0;

    // Reset state
    repeat (3) @(negedge cp);
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_eol",   out_eol, 0);
    chk("rst_out_src",   out_src, 0);
    chk("rst_trunc",     trunc_err, 0);
    chk("rst_lines",     lines_done, 0);
    chk("rst_rdy0",      req0_ready, 0);
    chk("rst_rdy1",      req1_ready, 0);
    reset = 0;

    // Idle with no requests
    repeat (10) begin
      @(negedge cp); #3;
      chk("idle_out_valid", out_valid, 0);
      chk("idle_rdy0", req0_ready, 0);
      chk("idle_rdy1", req1_ready, 0);
      chk("idle_lines", lines_done, 0);
    end

    // Single 4-beat line from requester 0
    base = log_q.size();
    send(0, 24'h000001, 4, 1, 99, t0);
    drain();
    chk("t2_beats", log_q.size() - base, 4);
    if (log_q.size() > base) chk("t2_latency", log_q[base].cyc - t0, 2);
    chk("t2_lines", lines_done, 1);

    // Requester 1 line with a 5-cycle output stall
    fork
      send(1, 24'h000100, 4, 1, 99, t0);
      begin
        w = 0;
        @(negedge cp); #1;
        while (!(out_valid && out_src) && w < 50) begin
          @(negedge cp); #1;
          w++;
        end
        if (w >= 50) chk("stall_wait_timeout", 0, 1);
        out_ready = 0;
        hold_pix = out_pixel;
        repeat (5) begin
          @(negedge cp); #3;
          chk("stall_valid", out_valid, 1);
          chk("stall_pixel", out_pixel, hold_pix);
          chk("stall_src",   out_src, 1);
          chk("stall_rdy1",  req1_ready, 0);
          chk("stall_rdy0",  req0_ready, 0);
        end
        @(negedge cp); #1;
        out_ready = 1;
      end
    join
    drain();
    chk("t4_lines", lines_done, m_lines);

    // Both requesters continuously valid, 3-beat lines
    base = log_q.size();
    fork
      begin
        send(0, 24'h000010, 3, 1, 99, t0);
        send(0, 24'h000020, 3, 1, 99, t0);
      end
      begin
        send(1, 24'h000030, 3, 1, 99, t1);
        send(1, 24'h000040, 3, 1, 99, t1);
      end
    join
    drain();
    chk("t3_beats", log_q.size() - base, 12);
    if (log_q.size() - base >= 12) begin
      for (int k = 0; k < 12; k++) begin
        chk("t3_src_order", log_q[base+k].b.src, (k / 3) % 2);
        if (k > 0) chk("t3_beat_gap", log_q[base+k].cyc - log_q[base+k-1].cyc, (k % 3 == 0) ? 2 : 1);
      end
    end
    chk("t3_lines", lines_done, m_lines);

    // Truncation: 10 beats without eol, then a closing beat
    base = log_q.size();
    send(0, 24'h000200, 10, 0, 99, t0);
    send(0, 24'h00020A, 1, 1, 99, t0);
    drain();
    chk("t5_beats", log_q.size() - base, 11);
    chk("t5_trunc_count", n_trunc, 1);
    if (log_q.size() - base >= 9) chk("t5_rearb_gap", log_q[base+8].cyc - log_q[base+7].cyc, 2);
    chk("t5_lines", lines_done, m_lines);

    // Asynchronous reset during beat 2 of a 5-beat line
    send(0, 24'h000300, 5, 1, 2, t0);
    reset = 1;
    #1;
    chk("rst6_out_valid", out_valid, 0);
    chk("rst6_out_pixel", out_pixel, 0);
    chk("rst6_out_eol",   out_eol, 0);
    chk("rst6_out_src",   out_src, 0);
    chk("rst6_lines",     lines_done, 0);
    chk("rst6_rdy0",      req0_ready, 0);
    chk("rst6_rdy1",      req1_ready, 0);
    exp_q.delete();
    mcnt[0] = 0; mcnt[1] = 0;
    m_lines = 0;
    repeat (2) @(negedge cp);
    #1;
    reset = 0;
    base = log_q.size();
    fork
      send(1, 24'h000400, 2, 1, 99, t1);
      send(0, 24'h000500, 2, 1, 99, t0);
    join
    drain();
    chk("t6_beats", log_q.size() - base, 4);
    if (log_q.size() - base >= 4) begin
      chk("t6_first_src", log_q[base].b.src, 0);
      chk("t6_second_src", log_q[base+2].b.src, 1);
    end
    chk("t6_lines", lines_done, 2);
    chk("t6_trunc_count", n_trunc, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
